// File: rtl/bump_turn_ctrl_pkg.sv
// Shared encodings for the bump/turn maneuver controller: drive commands,
// FSM states and the maneuver timer width.
package bump_turn_ctrl_pkg;

  localparam int TIMER_W = 11;

  typedef enum logic [1:0] {
    CMD_STOP = 2'b00,
    CMD_FWD  = 2'b01,
    CMD_REV  = 2'b10,
    CMD_TURN = 2'b11
  } drive_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FWD    = 2'b01,
    ST_BACKUP = 2'b10,
    ST_TURN   = 2'b11
  } state_e;

  function automatic drive_cmd_e state_cmd(input state_e s);
    drive_cmd_e c;
    case (s)
      ST_FWD:    c = CMD_FWD;
      ST_BACKUP: c = CMD_REV;
      ST_TURN:   c = CMD_TURN;
      default:   c = CMD_STOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bump_turn_ctrl_maneuver_timer.sv
// Loadable down counter timing the BACKUP and TURN phases.
// Priority: clear over load over decrement; decrement saturates at zero.
module maneuver_timer
  import bump_turn_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               dec,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bump_turn_ctrl.sv
// Bumper maneuver controller: reverse for BACKUP_CYCLES, spin for a random
// length/direction taken from the LFSR word, then resume forward drive.
// Build option BUMP_DEBOUNCE_EN: bump must be high for 3 samples after a low.
module bump_turn_ctrl
  import bump_turn_ctrl_pkg::*;
#(
  parameter int BACKUP_CYCLES = 64,
  parameter int TURN_MIN      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       bump,
  input  logic [9:0] random_number,
  output logic [1:0] drive_cmd,
  output logic       turn_dir,
  output logic       busy,
  output logic       maneuver_done,
  output state_e     state_dbg
);

  localparam logic [TIMER_W-1:0] BACKUP_LOAD = TIMER_W'(BACKUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TURN_BASE   = TIMER_W'(TURN_MIN - 1);

  state_e             state, state_nxt;
  logic               bump_edge;
  logic [9:0]         snap;
  logic               snap_load;
  logic               dir_load;
  logic               done_nxt;
  logic               tmr_clear, tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0] tmr_load_val;

`ifdef BUMP_DEBOUNCE_EN
  logic [2:0] bump_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bump_hist <= '0;
    end else begin
      bump_hist <= {bump_hist[1:0], bump};
    end
  end

  // Third consecutive high sample, with a low sample just before the run.
  assign bump_edge = bump & bump_hist[0] & bump_hist[1] & ~bump_hist[2];
`else
  logic bump_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bump_q <= 1'b0;
    end else begin
      bump_q <= bump;
    end
  end

  assign bump_edge = bump & ~bump_q;
`endif

  maneuver_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt    = state;
    tmr_clear    = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = BACKUP_LOAD;
    snap_load    = 1'b0;
    dir_load     = 1'b0;
    done_nxt     = 1'b0;
    // Dropping enable wins over any bump edge or timer expiry this cycle.
    if (!enable) begin
      state_nxt = ST_IDLE;
      tmr_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_FWD;
        ST_FWD: begin
          if (bump_edge) begin
            state_nxt = ST_BACKUP;
            tmr_load  = 1'b1;
            snap_load = 1'b1;
          end
        end
        ST_BACKUP: begin
          if (tmr_zero) begin
            state_nxt    = ST_TURN;
            tmr_load     = 1'b1;
            tmr_load_val = TURN_BASE + TIMER_W'(snap[9:1]);
            dir_load     = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_TURN: begin
          if (bump_edge) begin
            state_nxt = ST_BACKUP;
            tmr_load  = 1'b1;
            snap_load = 1'b1;
          end else if (tmr_zero) begin
            state_nxt = ST_FWD;
            done_nxt  = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      drive_cmd     <= CMD_STOP;
      turn_dir      <= 1'b0;
      maneuver_done <= 1'b0;
      snap          <= '0;
    end else begin
      state         <= state_nxt;
      drive_cmd     <= state_cmd(state_nxt);
      maneuver_done <= done_nxt;
      if (dir_load) begin
        turn_dir <= snap[0];
      end
      if (snap_load) begin
        snap <= random_number;
      end
    end
  end

  assign busy      = (state == ST_BACKUP) || (state == ST_TURN);
  assign state_dbg = state;

endmodule

// File: tb/tb_bump_turn_ctrl.sv
// Self-checking bench for bump_turn_ctrl: segment-length reference model with
// randomized LFSR words; honours BUMP_DEBOUNCE_EN when defined.
module tb_bump_turn_ctrl;
  import bump_turn_ctrl_pkg::*;

  localparam int BACKUP_CYCLES = 64;
  localparam int TURN_MIN      = 16;
  localparam int BOUND         = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       bump;
  logic [9:0] random_number;
  logic [1:0] drive_cmd;
  logic       turn_dir;
  logic       busy;
  logic       maneuver_done;
  state_e     state_dbg;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];

  bump_turn_ctrl #(
    .BACKUP_CYCLES (BACKUP_CYCLES),
    .TURN_MIN      (TURN_MIN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bump          (bump),
    .random_number (random_number),
    .drive_cmd     (drive_cmd),
    .turn_dir      (turn_dir),
    .busy          (busy),
    .maneuver_done (maneuver_done),
    .state_dbg     (state_dbg)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (maneuver_done === 1'b1) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got running required finished");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [9:0] rn, input bit hold);
    random_number = rn;
    bump = 1'b1;
`ifdef BUMP_DEBOUNCE_EN
    repeat (2) step();
`endif
    step();
    if (!hold) bump = 1'b0;
    random_number = 10'($urandom);
  endtask

  // Called at the first REV cycle; checks the whole maneuver against the model.
  task automatic check_maneuver(input logic [9:0] rn, input string tag);
    int n;
    int d0;
    logic [11:0] e;
    exp_q.push_back(12'(BACKUP_CYCLES));
    exp_q.push_back(12'(rn & 10'h1));
    exp_q.push_back(12'(TURN_MIN + (rn >> 1)));
    d0 = done_cnt;
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_in_rev: got %0b required 1", tag, busy);
    else n_pass++;
    n = 0;
    while (drive_cmd === CMD_REV && n < BOUND) begin
      n++;
      random_number = 10'($urandom);
      step();
    end
    e = exp_q.pop_front();
    n_total++;
    if (n !== int'(e)) $display("FAIL %s rev_len: got %0d required %0d", tag, n, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (drive_cmd !== CMD_TURN || turn_dir !== e[0])
      $display("FAIL %s turn_dir: got cmd %b dir %0b required cmd 11 dir %0b", tag, drive_cmd, turn_dir, e[0]);
    else n_pass++;
    n = 0;
    while (drive_cmd === CMD_TURN && n < BOUND) begin
      n++;
      random_number = 10'($urandom);
      step();
    end
    e = exp_q.pop_front();
    n_total++;
    if (n !== int'(e)) $display("FAIL %s turn_len: got %0d required %0d", tag, n, e);
    else n_pass++;
    n_total++;
    if (drive_cmd !== CMD_FWD || maneuver_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done_pulse: got cmd %b done %0b busy %0b required cmd 01 done 1 busy 0",
               tag, drive_cmd, maneuver_done, busy);
    else n_pass++;
    step();
    n_total++;
    if (maneuver_done !== 1'b0 || done_cnt - d0 !== 1)
      $display("FAIL %s done_single: got done %0b pulses %0d required done 0 pulses 1",
               tag, maneuver_done, done_cnt - d0);
    else n_pass++;
  endtask

  // scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    bump = 1'b0;
    random_number = '0;
    repeat (3) step();
    n_total++;
    if (drive_cmd !== CMD_STOP || turn_dir !== 1'b0 || busy !== 1'b0 ||
        maneuver_done !== 1'b0 || state_dbg !== ST_IDLE)
      $display("FAIL reset_outputs: got cmd %b dir %0b busy %0b done %0b state %0d required all 0",
               drive_cmd, turn_dir, busy, maneuver_done, state_dbg);
    else n_pass++;
    rst = 1'b0;
    repeat (2) step();
    n_total++;
    if (drive_cmd !== CMD_STOP || state_dbg !== ST_IDLE)
      $display("FAIL idle_without_enable: got cmd %b state %0d required cmd 00 state 0", drive_cmd, state_dbg);
    else n_pass++;
    enable = 1'b1;
    step();
    n_total++;
    if (drive_cmd !== CMD_FWD || state_dbg !== ST_FWD)
      $display("FAIL enable_to_fwd: got cmd %b state %0d required cmd 01 state 1", drive_cmd, state_dbg);
    else n_pass++;
    step();
  endtask

  task automatic test_directed();
    logic [9:0] words[3];
    words[0] = 10'h2A5;
    words[1] = 10'h000;
    words[2] = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      press(words[i], 1'b0);
      n_total++;
      if (drive_cmd !== CMD_REV)
        $display("FAIL directed_latency: got cmd %b required 10 (word %h)", drive_cmd, words[i]);
      else n_pass++;
      check_maneuver(words[i], $sformatf("directed_%h", words[i]));
      repeat (3) step();
    end
  endtask

  task automatic test_random();
    logic [9:0] rn;
    for (int i = 0; i < 4; i++) begin
      rn = 10'($urandom_range(0, 1023));
      repeat ($urandom_range(1, 5)) step();
      press(rn, 1'b0);
      n_total++;
      if (drive_cmd !== CMD_REV)
        $display("FAIL random_latency: got cmd %b required 10 (word %h)", drive_cmd, rn);
      else n_pass++;
      check_maneuver(rn, $sformatf("random_%h", rn));
    end
  endtask

  task automatic test_retrigger();
    logic [9:0] rn;
    int n;
    int d0;
    rn = 10'($urandom_range(0, 1023));
    d0 = done_cnt;
    press(rn, 1'b0);
    n = 0;
    while (drive_cmd === CMD_REV && n < BOUND) begin
      n++;
      step();
    end
    n_total++;
    if (n !== BACKUP_CYCLES) $display("FAIL retrig_first_rev: got %0d required %0d", n, BACKUP_CYCLES);
    else n_pass++;
    repeat (9) step();
    n_total++;
    if (drive_cmd !== CMD_TURN) $display("FAIL retrig_in_turn: got cmd %b required 11", drive_cmd);
    else n_pass++;
    press(10'h004, 1'b0);
    n_total++;
    if (drive_cmd !== CMD_REV) $display("FAIL retrig_rev: got cmd %b required 10", drive_cmd);
    else n_pass++;
    check_maneuver(10'h004, "retrigger");
    n_total++;
    if (done_cnt - d0 !== 1) $display("FAIL retrig_done_total: got %0d required 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_held_bump();
    logic [9:0] rn;
    int bad;
    int d0;
    int rest;
    rn = 10'($urandom_range(0, 1023));
    d0 = done_cnt;
    press(rn, 1'b1);
    check_maneuver(rn, "held");
    rest = 1000 - (BACKUP_CYCLES + TURN_MIN + int'(rn >> 1) + 3);
    bad = 0;
    for (int i = 0; i < rest; i++) begin
      if (drive_cmd !== CMD_FWD) bad++;
      step();
    end
    n_total++;
    if (bad !== 0 || done_cnt - d0 !== 1)
      $display("FAIL held_single_maneuver: got non_fwd %0d pulses %0d required non_fwd 0 pulses 1",
               bad, done_cnt - d0);
    else n_pass++;
    bump = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_enable_drop();
    int d0;
    d0 = done_cnt;
    press(10'($urandom), 1'b0);
    repeat (19) step();
    n_total++;
    if (drive_cmd !== CMD_REV) $display("FAIL drop_in_backup: got cmd %b required 10", drive_cmd);
    else n_pass++;
    enable = 1'b0;
    bump = 1'b1;
    step();
    bump = 1'b0;
    n_total++;
    if (drive_cmd !== CMD_STOP || state_dbg !== ST_IDLE || busy !== 1'b0)
      $display("FAIL drop_to_idle: got cmd %b state %0d busy %0b required cmd 00 state 0 busy 0",
               drive_cmd, state_dbg, busy);
    else n_pass++;
    repeat (5) step();
    n_total++;
    if (drive_cmd !== CMD_STOP || done_cnt - d0 !== 0)
      $display("FAIL drop_stays_idle: got cmd %b pulses %0d required cmd 00 pulses 0", drive_cmd, done_cnt - d0);
    else n_pass++;
    enable = 1'b1;
    step();
    n_total++;
    if (drive_cmd !== CMD_FWD) $display("FAIL drop_reenable: got cmd %b required 01", drive_cmd);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_turn();
    int n;
    press(10'h2A5, 1'b0);
    n = 0;
    while (drive_cmd !== CMD_TURN && n < BOUND) begin
      n++;
      step();
    end
    repeat (5) step();
    n_total++;
    if (drive_cmd !== CMD_TURN || turn_dir !== 1'b1)
      $display("FAIL pre_reset_turn: got cmd %b dir %0b required cmd 11 dir 1", drive_cmd, turn_dir);
    else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_total++;
    if (drive_cmd !== CMD_STOP || turn_dir !== 1'b0 || busy !== 1'b0 ||
        maneuver_done !== 1'b0 || state_dbg !== ST_IDLE)
      $display("FAIL async_reset: got cmd %b dir %0b busy %0b done %0b state %0d required all 0",
               drive_cmd, turn_dir, busy, maneuver_done, state_dbg);
    else n_pass++;
    #1 rst = 1'b0;
    step();
    n_total++;
    if (drive_cmd !== CMD_FWD) $display("FAIL reset_reenable: got cmd %b required 01", drive_cmd);
    else n_pass++;
    step();
  endtask

`ifdef BUMP_DEBOUNCE_EN
  task automatic test_debounce();
    int bad;
    logic [9:0] rn;
    for (int g = 1; g <= 2; g++) begin
      bump = 1'b1;
      repeat (g) step();
      bump = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (drive_cmd !== CMD_FWD) bad++;
        step();
      end
      n_total++;
      if (bad !== 0) $display("FAIL glitch_%0d_ignored: got non_fwd %0d required 0", g, bad);
      else n_pass++;
    end
    rn = 10'($urandom_range(0, 1023));
    random_number = rn;
    bump = 1'b1;
    step();
    n_total++;
    if (drive_cmd !== CMD_FWD) $display("FAIL debounce_edge1: got cmd %b required 01", drive_cmd);
    else n_pass++;
    step();
    n_total++;
    if (drive_cmd !== CMD_FWD) $display("FAIL debounce_edge2: got cmd %b required 01", drive_cmd);
    else n_pass++;
    step();
    bump = 1'b0;
    random_number = 10'($urandom);
    n_total++;
    if (drive_cmd !== CMD_REV) $display("FAIL debounce_edge3: got cmd %b required 10", drive_cmd);
    else n_pass++;
    check_maneuver(rn, "debounce");
  endtask
`else
  task automatic test_debounce();
    bump = 1'b1;
    step();
    bump = 1'b0;
    n_total++;
    if (drive_cmd !== CMD_REV) $display("FAIL single_sample_edge: got cmd %b required 10", drive_cmd);
    else n_pass++;
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (2) step();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_retrigger();
    test_held_bump();
    test_enable_drop();
    test_debounce();
    test_reset_mid_turn();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bump_turn_ctrl.md
# bump_turn_ctrl

Maneuver controller sitting directly downstream of the 10-bit LFSR random number generator. On a bumper collision it backs the robot up for a fixed time, then spins in place for a random duration and direction derived from the LFSR word, then resumes forward drive. Outputs feed the motor driver stage as a 2-bit drive command plus turn direction.

## Interface
- BACKUP_CYCLES, 64, cycles of reverse drive per maneuver (1..2047)
- TURN_MIN, 16, minimum turn cycles; turn length = TURN_MIN + random_number[9:1] (TURN_MIN 1..1536)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run request; low forces stop
- bump  in  1  bumper contact, synchronous to clk, level
- random_number  in  10  current LFSR word
- drive_cmd  out  2  00 STOP, 01 FWD, 10 REV, 11 TURN (registered)
- turn_dir  out  1  0 = left, 1 = right; valid while drive_cmd = 11
- busy  out  1  high in BACKUP or TURN
- maneuver_done  out  1  one-cycle pulse when a maneuver completes

## Operation
- States: IDLE, FWD, BACKUP, TURN.
- Reset: state IDLE; drive_cmd 00, turn_dir 0, busy 0, maneuver_done 0; timer 0, bump history cleared.
- bump_edge = bump high and previous-cycle bump low.
- IDLE -> FWD when enable high.
- FWD -> BACKUP on bump_edge; random_number latched on the same edge (10-bit snapshot); timer loaded BACKUP_CYCLES-1.
- BACKUP: timer decrements; at 0 -> TURN, timer loaded TURN_MIN + snap[9:1] - 1 (11-bit unsigned add, no overflow within param range), turn_dir <= snap[0].
- TURN: timer decrements; at 0 -> FWD, maneuver_done pulses.
- bump_edge in BACKUP: ignored. bump_edge in TURN: re-enter BACKUP, fresh snapshot, full BACKUP_CYCLES, no done pulse.
- bump held high continuously: one maneuver only; new maneuver needs a low-to-high transition.
- enable low in any state -> IDLE next edge, timer cleared, no done pulse; overrides simultaneous bump_edge or timer expiry.
- busy derived from registered state; turn_dir holds last value outside TURN.

## Timing
- bump_edge sampled at edge k -> drive_cmd = 10 after edge k (1-cycle latency).
- drive_cmd = 10 for exactly BACKUP_CYCLES cycles, then 11 for exactly TURN_MIN + snap[9:1] cycles.
- maneuver_done high during first FWD cycle after TURN, exactly one cycle.
- enable rising at edge k -> drive_cmd = 01 after edge k.
- random_number is sampled only at the bump_edge cycle; later LFSR changes have no effect.

## Configuration
- BUMP_DEBOUNCE_EN defined: bump accepted only after 3 consecutive high samples following a low sample; bump_edge asserts on the third high sample (latency +2 cycles); glitches of 1-2 cycles ignored.
- Undefined: single-sample rising edge as above.

## Structure
- Shared package: drive_cmd encodings (STOP/FWD/REV/TURN), state encodings, timer width constant (11).
- Sub-module maneuver_timer: 11-bit loadable down counter with load, dec, clear, zero flag; async active-high reset.

## Test plan
- Reset mid-TURN (rst pulse asynchronous to clk) -> all outputs 0 immediately, state IDLE; enable then gives drive_cmd 01 after one edge.
- enable=1, random_number=10'h2A5, bump edge -> 64 cycles REV, 354 cycles TURN with turn_dir=1, then FWD with one-cycle maneuver_done.
- random_number=10'h000 -> 16 TURN cycles, turn_dir=0; random_number=10'h3FF -> 527 TURN cycles, turn_dir=1.
- Second bump edge at TURN cycle 10 with random_number=10'h004 -> new 64-cycle BACKUP, then 18 TURN cycles, turn_dir=0; single done pulse total.
- bump held high 1000 cycles; enable dropped at BACKUP cycle 20 together with a bump edge -> one maneuver only; IDLE next edge, no done pulse.
- BUMP_DEBOUNCE_EN: 2-cycle bump glitch -> no maneuver; 3-cycle bump -> drive_cmd 10 three edges after first high sample.
